// File: rtl/sync_sel_pkg.sv
// Shared types and helpers for the sync source selector.
package sync_sel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // Next set bit of mask strictly after ptr (wrapping modulo n); ptr itself if none.
  function automatic logic [3:0] next_enabled(input logic [3:0] ptr,
                                              input logic [15:0] mask,
                                              input int n);
    logic [3:0] res;
    int idx;
    res = ptr;
    for (int i = 15; i >= 1; i--) begin
      if (i < n) begin
        idx = (int'(ptr) + i) % n;
        if (mask[4'(idx)]) res = 4'(idx);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus a delay flop; emits a one-cycle pulse per rising edge.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic [2:0] sh_q;
  logic [2:0] sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  assign rise = sh_q[1] & ~sh_q[2];

endmodule

// File: rtl/sync_source_selector.sv
// Round-robin measures candidate sync inputs one window at a time and locks onto
// the first that is fast enough, releasing it after repeated slow windows.
module sync_source_selector
  import sync_sel_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int WINDOW_CNT   = 200,
  parameter int ENTER_TH     = 26,
  parameter int EXIT_TH      = 20,
  parameter int LOSS_WINDOWS = 2,
  parameter int WIDTH        = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          sig_in,
  input  logic [N_CH-1:0]          ch_enable,
  output logic                     src_valid,
  output logic [$clog2(N_CH)-1:0]  src_sel,
  output logic                     sync_out,
  output logic [WIDTH-1:0]         edge_cnt_last,
  output logic                     win_done
);

  localparam int SW = $clog2(N_CH);
  localparam int MW = $clog2(LOSS_WINDOWS + 1);

  logic [N_CH-1:0] rise;

  for (genvar k = 0; k < N_CH; k++) begin : g_sync
    sync_edge_detect u_det (
      .clk  (clk),
      .rst  (rst),
      .d    (sig_in[k]),
      .rise (rise[k])
    );
  end

  state_t           state_q, state_d;
  logic [SW-1:0]    sel_q, sel_d;
  logic [WIDTH-1:0] win_q, win_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [MW-1:0]    miss_q, miss_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             valid_q, valid_d;
  logic             sync_q, sync_d;
  logic             done_q, done_d;

  logic             any_en, sel_en, rise_sel, win_end;
  logic [WIDTH-1:0] fin_cnt;
  logic [SW-1:0]    next_sel, lowest_sel;

  assign any_en     = |ch_enable;
  assign sel_en     = ch_enable[sel_q];
  assign rise_sel   = rise[sel_q];
  assign win_end    = (win_q == WIDTH'(WINDOW_CNT - 1));
  assign next_sel   = SW'(next_enabled(4'(sel_q), 16'(ch_enable), N_CH));
  assign lowest_sel = SW'(next_enabled(4'(N_CH - 1), 16'(ch_enable), N_CH));
  // Saturating count including an edge on the current cycle, so a last-cycle edge closes with its window.
  assign fin_cnt    = (rise_sel && (edge_q != '1)) ? edge_q + 1'b1 : edge_q;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    win_d   = win_q + 1'b1;
    edge_d  = fin_cnt;
    miss_d  = miss_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        win_d  = '0;
        edge_d = '0;
        miss_d = '0;
        if (any_en) begin
          state_d = ST_SCAN;
          sel_d   = lowest_sel;
        end
      end
      ST_SCAN: begin
        if (!any_en || !sel_en) begin
          state_d = any_en ? ST_SCAN : ST_IDLE;
          sel_d   = any_en ? next_sel : sel_q;
          win_d   = '0;
          edge_d  = '0;
        end else if (win_end) begin
          done_d = 1'b1;
          last_d = fin_cnt;
          win_d  = '0;
          edge_d = '0;
          miss_d = '0;
          if (fin_cnt >= WIDTH'(ENTER_TH)) state_d = ST_LOCKED;
          else                              sel_d   = next_sel;
        end
      end
      ST_LOCKED: begin
        if (!sel_en) begin
          state_d = any_en ? ST_SCAN : ST_IDLE;
          sel_d   = any_en ? next_sel : sel_q;
          win_d   = '0;
          edge_d  = '0;
          miss_d  = '0;
        end else if (win_end) begin
          done_d = 1'b1;
          last_d = fin_cnt;
          win_d  = '0;
          edge_d = '0;
          if (fin_cnt >= WIDTH'(EXIT_TH)) begin
            miss_d = '0;
          end else if (int'(miss_q) + 1 >= LOSS_WINDOWS) begin
            miss_d  = '0;
            state_d = ST_SCAN;
            sel_d   = next_sel;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        win_d   = '0;
        edge_d  = '0;
        miss_d  = '0;
      end
    endcase
    valid_d = (state_d == ST_LOCKED);
    sync_d  = (state_d == ST_LOCKED) && rise_sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      win_q   <= '0;
      edge_q  <= '0;
      miss_q  <= '0;
      last_q  <= '0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      win_q   <= win_d;
      edge_q  <= edge_d;
      miss_q  <= miss_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
    end
  end

  assign src_valid     = valid_q;
  assign src_sel       = sel_q;
  assign sync_out      = sync_q;
  assign edge_cnt_last = last_q;
  assign win_done      = done_q;

endmodule
